// File: rtl/fix_tx_pkg.sv
// Shared constants, classifier states and the trailer matcher step used by the
// FIX transmit drain.
package fix_tx_pkg;

   localparam logic [7:0] SOH      = 8'h01;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_1  = 8'h31;
   localparam logic [7:0] ASCII_8  = 8'h38;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_EQ = 8'h3d;

   localparam int unsigned DEFAULT_MAX_MSG_LEN = 512;

   typedef enum logic [3:0] {
      StStart,
      StBody,
      StSoh,
      St1,
      St10,
      StEq,
      StD1,
      StD2,
      StD3,
      StResync
   } cls_state_e;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= ASCII_9);
   endfunction

   // One step of the <SOH>10=ddd<SOH> matcher; StStart means the trailer completed.
   function automatic cls_state_e trl_next(input cls_state_e s, input logic [7:0] b);
      cls_state_e n;
      n = (b == SOH) ? StSoh : StBody;
      case (s)
         StSoh:   if (b == ASCII_1)  n = St1;
         St1:     if (b == ASCII_0)  n = St10;
         St10:    if (b == ASCII_EQ) n = StEq;
         StEq:    if (is_digit(b))   n = StD1;
         StD1:    if (is_digit(b))   n = StD2;
         StD2:    if (is_digit(b))   n = StD3;
         StD3:    if (b == SOH)      n = StStart;
         default: ;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/fix_tx_skid.sv
// Two-entry output buffer; the head entry only changes on pop or on a push into
// an empty buffer, so a presented beat stays stable until accepted.
module fix_tx_skid #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             valid_o,
   output logic [1:0]       occ_o
);

   logic [Width-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]       occ_q, occ_d, lvl;

   always_comb begin
      e0_d = e0_q;
      e1_d = e1_q;
      lvl  = occ_q - {1'b0, pop_i};
      if (pop_i) e0_d = e1_q;
      if (push_i) begin
         if (lvl == 2'd0) e0_d = push_data_i;
         else             e1_d = push_data_i;
      end
      occ_d = lvl + {1'b0, push_i};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         occ_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         occ_q <= occ_d;
      end
   end

   assign head_o  = e0_q;
   assign valid_o = (occ_q != 2'd0);
   assign occ_o   = occ_q;

endmodule

// File: rtl/fix_tx_drain.sv
// Drains FIX messages from the transmit FIFO to the TOE, marking message boundaries
// and checking each trailer checksum against the bytes the message actually carries.
module fix_tx_drain
   import fix_tx_pkg::*;
#(
   parameter int unsigned MAX_MSG_LEN = DEFAULT_MAX_MSG_LEN,
   parameter int unsigned LEN_W       = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty_i,
   input  logic [7:0]       fifo_data_i,
   output logic             fifo_read_o,
   input  logic             tx_ready_i,
   output logic             tx_valid_o,
   output logic [7:0]       tx_data_o,
   output logic             tx_sop_o,
   output logic             tx_eop_o,
   output logic [LEN_W-1:0] tx_len_o,
   output logic             tx_chk_err_o,
   output logic             overflow_o,
   output logic [15:0]      msg_count_o
);

   localparam int unsigned EntW = 8 + 1 + 1 + LEN_W + 1;

   cls_state_e       state_q, state_d, rs_q, rs_d, mt_src, mt_nxt;
   logic [7:0]       sum_q, sum_d, snap_q, snap_d, sum_nxt;
   logic [9:0]       val_q, val_d, val_nxt;
   logic [LEN_W-1:0] cnt_q, cnt_d, cnt_nxt;
   logic             rd_q, run_q, is_start, in_rs, trl_hit, msg_eop, ovf, push, pop;
   logic [15:0]      msg_cnt_q;
   logic [1:0]       occ;
   logic [2:0]       lvl;
   logic [EntW-1:0]  push_ent, head_ent;

   // Classifier: runs on the byte returned for last cycle's read (rd_q).
   always_comb begin
      is_start = (state_q == StStart);
      in_rs    = (state_q == StResync);
      sum_nxt  = (is_start ? 8'h00 : sum_q) + fifo_data_i;
      cnt_nxt  = is_start ? LEN_W'(1) : cnt_q + LEN_W'(1);
      mt_src   = in_rs ? rs_q : (is_start ? StBody : state_q);
      mt_nxt   = trl_next(mt_src, fifo_data_i);
      trl_hit  = (mt_nxt == StStart);
      msg_eop  = rd_q && !in_rs && trl_hit;
      ovf      = rd_q && !in_rs && !trl_hit && (cnt_nxt == LEN_W'(MAX_MSG_LEN));
      val_nxt  = (mt_nxt == StD1) ? {6'b0, fifo_data_i[3:0]}
                                  : val_q * 10'd10 + {6'b0, fifo_data_i[3:0]};

      state_d = state_q;
      rs_d    = rs_q;
      sum_d   = sum_q;
      snap_d  = snap_q;
      val_d   = val_q;
      cnt_d   = cnt_q;
      if (rd_q) begin
         sum_d = sum_nxt;
         cnt_d = cnt_nxt;
         // The SOH opening a trailer is part of the checksummed span; the closing one is not.
         if (fifo_data_i == SOH && !trl_hit) snap_d = sum_nxt;
         if (mt_nxt inside {StD1, StD2, StD3}) val_d = val_nxt;
         if (in_rs) begin
            rs_d = mt_nxt;
            if (trl_hit) state_d = StStart;
         end else if (trl_hit) begin
            state_d = StStart;
         end else if (ovf) begin
            state_d = StResync;
            rs_d    = mt_nxt;
         end else begin
            state_d = mt_nxt;
         end
      end
   end

   assign push     = rd_q && !in_rs;
   assign push_ent = {fifo_data_i, is_start, msg_eop | ovf, cnt_nxt,
                      msg_eop ? (val_q != {2'b00, snap_q}) : ovf};
   assign pop      = tx_valid_o && tx_ready_i;

   // Read only when the buffer is guaranteed room for the byte once it lands.
   assign lvl         = {1'b0, occ} + {2'b00, rd_q};
   assign fifo_read_o = run_q && !fifo_empty_i && (lvl < 3'd2 + {2'b00, pop});
   assign overflow_o  = ovf;
   assign msg_count_o = msg_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StStart;
         rs_q      <= StBody;
         sum_q     <= '0;
         snap_q    <= '0;
         val_q     <= '0;
         cnt_q     <= '0;
         rd_q      <= 1'b0;
         run_q     <= 1'b0;
         msg_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         sum_q   <= sum_d;
         snap_q  <= snap_d;
         val_q   <= val_d;
         cnt_q   <= cnt_d;
         rd_q    <= fifo_read_o;
         run_q   <= 1'b1;
         if (pop && tx_eop_o) msg_cnt_q <= msg_cnt_q + 16'd1;
      end
   end

   fix_tx_skid #(
      .Width (EntW)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_ent),
      .pop_i       (pop),
      .head_o      (head_ent),
      .valid_o     (tx_valid_o),
      .occ_o       (occ)
   );

   assign {tx_data_o, tx_sop_o, tx_eop_o, tx_len_o, tx_chk_err_o} = head_ent;

endmodule
